// File: rtl/pwm_peripheral.sv
// PWM pin driver fed by SPI register writes.
// 16 pins: off, static high, or a shared 8-bit PWM.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [15:0] out,
  output logic        wr_err,
  output logic        period_start
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [15:0]   en_out;
  logic [15:0]   en_pwm;
  logic [7:0]    duty;
  logic [7:0]    duty_active;
  logic [7:0]    duty_nxt;
  logic [7:0]    pwm_cnt;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          wrap;
  logic          pwm_sig;

  assign tick = (pre_cnt == PRE_MAX);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // a duty write landing on the wrap edge is forwarded
  assign duty_nxt = (wr_valid && wr_addr == 7'h04)
                  ? wr_data : duty;

  assign pwm_sig = (duty_active == 8'hFF) ||
                   (pwm_cnt < duty_active);

  always_ff @(posedge clk) begin
    if (rst) begin
      en_out       <= '0;
      en_pwm       <= '0;
      duty         <= '0;
      duty_active  <= '0;
      pwm_cnt      <= '0;
      pre_cnt      <= '0;
      out          <= '0;
      wr_err       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (wr_valid) begin
        unique case (wr_addr)
          7'h00:   en_out[7:0]  <= wr_data;
          7'h01:   en_out[15:8] <= wr_data;
          7'h02:   en_pwm[7:0]  <= wr_data;
          7'h03:   en_pwm[15:8] <= wr_data;
          7'h04:   duty         <= wr_data;
          default: wr_err       <= 1'b1;
        endcase
      end
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick)
        pwm_cnt <= pwm_cnt + 8'd1;
      if (wrap)
        duty_active <= duty_nxt;
      period_start <= wrap;
      out <= en_out & (~en_pwm | {16{pwm_sig}});
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: static writes, PWM shape,
// duty shadowing, unmapped-address flag, reset.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] out1, out2;
  logic        err1, err2;
  logic        ps1, ps2;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .out(out1), .wr_err(err1), .period_start(ps1)
  );

  pwm_peripheral #(.PRESCALE(2)) dut2 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .out(out2), .wr_err(err2), .period_start(ps2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t exp_q[$];
  logic exp_bits[$];
  bit   pwm_chk = 1'b0;
  int   pwm_pin = 0;
  logic [7:0] model_duty = 8'h00;
  int   gap1 = -1;
  int   gap2 = -1;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // reference duty register, as seen by the wrap edge
  always @(posedge clk) begin
    if (rst)
      model_duty <= 8'h00;
    else if (wr_valid && wr_addr == 7'h04)
      model_duty <= wr_data;
  end

  // period spacing and per-sample PWM scoreboard
  always @(negedge clk) begin
    if (rst) begin
      gap1 = -1;
      gap2 = -1;
    end else begin
      if (gap1 >= 0) gap1++;
      if (gap2 >= 0) gap2++;
      if (ps1) begin
        if (gap1 >= 0) chk("gap1", 16'(gap1), 16'd256);
        gap1 = 0;
      end
      if (ps2) begin
        if (gap2 >= 0) chk("gap2", 16'(gap2), 16'd512);
        gap2 = 0;
      end
    end
    if (!pwm_chk) begin
      exp_bits.delete();
    end else begin
      if (exp_bits.size() > 0) begin
        logic e;
        e = exp_bits.pop_front();
        chk("pwm_pin", 16'(out1[pwm_pin]), 16'(e));
      end
      if (ps1)
        for (int j = 0; j < 256; j++)
          exp_bits.push_back((model_duty == 8'hFF) ||
                             (j < int'(model_duty)));
    end
  end

  task automatic wr(input logic [6:0] a,
                    input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_ps();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge clk);
      seen = ps1;
    end
    chk("ps_wait", 16'(seen), 16'd1);
  endtask

  // starts on a period_start sample, ends on the next
  task automatic count_period(input int pin,
                              input int wr_at,
                              input logic [7:0] wv,
                              output int highs);
    highs = 0;
    for (int n = 0; n < 256; n++) begin
      if (n == wr_at) begin
        wr_valid = 1'b1;
        wr_addr  = 7'h04;
        wr_data  = wv;
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      highs += int'(out1[pin]);
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    int   h;
    exp_t x;

    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 7'h00;
    wr_data  = 8'hFF;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("rst_out1", out1, 16'h0000);
    chk("rst_out2", out2, 16'h0000);
    chk("rst_err", 16'(err1), 16'd0);
    chk("rst_ps", 16'(ps1), 16'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold", out1, 16'h0000);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst", out1, 16'h0000);
    @(negedge clk);
    chk("post_rst2", out2, 16'h0000);

    exp_q.push_back('{"b2b_lo", 16'h00A5});
    exp_q.push_back('{"b2b", 16'h3CA5});
    wr(7'h00, 8'hA5);
    wr(7'h01, 8'h3C);
    x = exp_q.pop_front();
    chk(x.tag, out1, x.v);
    @(negedge clk);
    x = exp_q.pop_front();
    chk(x.tag, out1, x.v);
    chk({x.tag, "_p2"}, out2, x.v);
    chk("b2b_err", 16'(err1), 16'd0);

    wr(7'h00, 8'h00);
    wr(7'h01, 8'h00);
    wr(7'h02, 8'h01);
    wr(7'h00, 8'h01);
    wr(7'h04, 8'h40);
    pwm_pin = 0;
    pwm_chk = 1'b1;
    wait_ps();
    count_period(0, -1, 8'h00, h);
    chk("duty40", 16'(h), 16'd64);
    count_period(0, -1, 8'h00, h);
    chk("duty40_b", 16'(h), 16'd64);

    pwm_chk = 1'b0;
    wr(7'h00, 8'h00);
    wr(7'h02, 8'h00);
    wr(7'h01, 8'h01);
    wr(7'h03, 8'h01);
    wr(7'h04, 8'h00);
    pwm_pin = 8;
    pwm_chk = 1'b1;
    wait_ps();
    count_period(8, -1, 8'h00, h);
    chk("duty00", 16'(h), 16'd0);
    wr(7'h04, 8'hFF);
    chk("ff_pending", 16'(out1[8]), 16'd0);
    wait_ps();
    count_period(8, -1, 8'h00, h);
    chk("dutyFF", 16'(h), 16'd256);

    pwm_chk = 1'b0;
    wr(7'h01, 8'h00);
    wr(7'h03, 8'h00);
    wr(7'h00, 8'h01);
    wr(7'h02, 8'h01);
    wr(7'h04, 8'h80);
    pwm_pin = 0;
    pwm_chk = 1'b1;
    wait_ps();
    count_period(0, 100, 8'h10, h);
    chk("shadow80", 16'(h), 16'd128);
    count_period(0, 255, 8'h30, h);
    chk("duty10", 16'(h), 16'd16);
    count_period(0, -1, 8'h00, h);
    chk("wrap_fwd30", 16'(h), 16'd48);

    pwm_chk = 1'b0;
    wr(7'h02, 8'h00);
    wr(7'h03, 8'h00);
    wr(7'h00, 8'h5A);
    wr(7'h01, 8'hC3);
    @(negedge clk);
    chk("static", out1, 16'hC35A);
    wr(7'h05, 8'hFF);
    chk("unmap05_err", 16'(err1), 16'd1);
    @(negedge clk);
    chk("unmap05_out", out1, 16'hC35A);
    wr(7'h7F, 8'h00);
    @(negedge clk);
    chk("unmap7F_out", out2, 16'hC35A);
    chk("unmap7F_err", 16'(err2), 16'd1);
    wr(7'h00, 8'h0F);
    @(negedge clk);
    chk("after_err", out1, 16'hC30F);
    chk("err_sticky", 16'(err1), 16'd1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_err_clr", 16'(err1), 16'd0);
    chk("rst_out_clr", out1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
